// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-direction traffic light controller.
// Tracks each direction's lamp phase and flags illegal codes, sequences, conflicts and yellow timing.
module traffic_light_monitor #(
    parameter int YMIN = 2,
    parameter int YMAX = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Ra,
    input  logic       Ga,
    input  logic       Ya,
    input  logic       Rb,
    input  logic       Gb,
    input  logic       Yb,
    input  logic       clr_err,
    output logic       err_conflict,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_ydur,
    output logic       err_pulse,
    output logic [7:0] phases_a,
    output logic [7:0] phases_b
);

    typedef enum logic [1:0] {
        ST_UNK,
        ST_GREEN,
        ST_YELLOW,
        ST_RED
    } light_t;

    localparam logic [7:0] YMIN_L = 8'(YMIN);
    localparam logic [7:0] YMAX_L = 8'(YMAX);

    logic [2:0] lamps     [2];
    light_t     state_q   [2];
    light_t     state_d   [2];
    logic [7:0] dwell_q   [2];
    logic [7:0] dwell_d   [2];
    logic [7:0] phases_q  [2];
    logic [7:0] phases_d  [2];
    logic       yleg_q    [2];
    logic       yleg_d    [2];
    logic       dec_valid [2];
    light_t     dec_state [2];
    logic       legal     [2];
    logic       code_v    [2];
    logic       seq_v     [2];
    logic       ydur_v    [2];
    logic       conflict_v;
    logic       any_v;

    assign lamps[0] = {Ra, Ga, Ya};
    assign lamps[1] = {Rb, Gb, Yb};

    assign phases_a = phases_q[0];
    assign phases_b = phases_q[1];

    // yleg remembers whether the current yellow was entered from green, so only full cycles count as phases
    always_comb begin
        conflict_v = (Ga | Ya) & (Gb | Yb);
        for (int i = 0; i < 2; i++) begin
            state_d[i]   = state_q[i];
            dwell_d[i]   = dwell_q[i];
            phases_d[i]  = phases_q[i];
            yleg_d[i]    = yleg_q[i];
            code_v[i]    = 1'b0;
            seq_v[i]     = 1'b0;
            ydur_v[i]    = 1'b0;
            dec_valid[i] = 1'b1;
            dec_state[i] = ST_UNK;
            legal[i]     = 1'b0;

            case (lamps[i])
                3'b100:  dec_state[i] = ST_RED;
                3'b010:  dec_state[i] = ST_GREEN;
                3'b001:  dec_state[i] = ST_YELLOW;
                default: dec_valid[i] = 1'b0;
            endcase

            if (!dec_valid[i]) begin
                code_v[i] = 1'b1;
            end else if (state_q[i] == ST_UNK) begin
                state_d[i] = dec_state[i];
                dwell_d[i] = 8'd1;
                yleg_d[i]  = 1'b0;
            end else if (dec_state[i] == state_q[i]) begin
                dwell_d[i] = (dwell_q[i] == 8'hFF) ? dwell_q[i] : dwell_q[i] + 8'd1;
                if (state_q[i] == ST_YELLOW && dwell_q[i] == YMAX_L) begin
                    ydur_v[i] = 1'b1;
                end
            end else begin
                legal[i] = (state_q[i] == ST_GREEN  && dec_state[i] == ST_YELLOW) ||
                           (state_q[i] == ST_YELLOW && dec_state[i] == ST_RED)    ||
                           (state_q[i] == ST_RED    && dec_state[i] == ST_GREEN);
                seq_v[i]   = !legal[i];
                state_d[i] = dec_state[i];
                dwell_d[i] = 8'd1;
                yleg_d[i]  = (state_q[i] == ST_GREEN && dec_state[i] == ST_YELLOW);
                if (state_q[i] == ST_YELLOW && dwell_q[i] < YMIN_L) begin
                    ydur_v[i] = 1'b1;
                end
                if (state_q[i] == ST_YELLOW && dec_state[i] == ST_RED && yleg_q[i]) begin
                    phases_d[i] = (phases_q[i] == 8'hFF) ? phases_q[i] : phases_q[i] + 8'd1;
                end
            end
        end
        any_v = conflict_v | code_v[0] | code_v[1] | seq_v[0] | seq_v[1] |
                ydur_v[0] | ydur_v[1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state_q[i]  <= ST_UNK;
                dwell_q[i]  <= 8'd0;
                phases_q[i] <= 8'd0;
                yleg_q[i]   <= 1'b0;
            end else begin
                state_q[i]  <= state_d[i];
                dwell_q[i]  <= dwell_d[i];
                phases_q[i] <= phases_d[i];
                yleg_q[i]   <= yleg_d[i];
            end
        end
    end

    // A violation seen in the same cycle as clr_err keeps its flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            err_conflict <= 1'b0;
            err_code     <= 1'b0;
            err_seq      <= 1'b0;
            err_ydur     <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            err_conflict <= conflict_v | (err_conflict & ~clr_err);
            err_code     <= code_v[0] | code_v[1] | (err_code & ~clr_err);
            err_seq      <= seq_v[0] | seq_v[1] | (err_seq & ~clr_err);
            err_ydur     <= ydur_v[0] | ydur_v[1] | (err_ydur & ~clr_err);
            err_pulse    <= any_v;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor with default YMIN=2, YMAX=6.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] CNF  = 5'b10000;
    localparam logic [4:0] CODE = 5'b01000;
    localparam logic [4:0] SEQ  = 5'b00100;
    localparam logic [4:0] YD   = 5'b00010;
    localparam logic [4:0] PUL  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Ra = 1'b0, Ga = 1'b0, Ya = 1'b0;
    logic       Rb = 1'b0, Gb = 1'b0, Yb = 1'b0;
    logic       clr_err = 1'b0;
    logic       err_conflict, err_code, err_seq, err_ydur, err_pulse;
    logic [7:0] phases_a, phases_b;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [2:0] a;
        logic [2:0] b;
        logic [4:0] flags;
        logic [7:0] pa;
        logic [7:0] pb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .Ra          (Ra),
        .Ga          (Ga),
        .Ya          (Ya),
        .Rb          (Rb),
        .Gb          (Gb),
        .Yb          (Yb),
        .clr_err     (clr_err),
        .err_conflict(err_conflict),
        .err_code    (err_code),
        .err_seq     (err_seq),
        .err_ydur    (err_ydur),
        .err_pulse   (err_pulse),
        .phases_a    (phases_a),
        .phases_b    (phases_b)
    );

    task automatic addVec(input logic r, input logic c, input logic [2:0] a, input logic [2:0] b,
                          input logic [4:0] f, input logic [7:0] pa, input logic [7:0] pb);
        vec_t v;
        v.rst   = r;
        v.clr   = c;
        v.a     = a;
        v.b     = b;
        v.flags = f;
        v.pa    = pa;
        v.pb    = pb;
        vecs.push_back(v);
    endtask

    // Drive one sample, then settle just after the capturing edge
    task automatic applyStimulus(input logic r, input logic c, input logic [2:0] a, input logic [2:0] b);
        rst         = r;
        clr_err     = c;
        {Ra, Ga, Ya} = a;
        {Rb, Gb, Yb} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] f, input logic [7:0] pa, input logic [7:0] pb);
        logic [4:0] got;
        got = {err_conflict, err_code, err_seq, err_ydur, err_pulse};
        checks++;
        if (got !== f || phases_a !== pa || phases_b !== pb) begin
            errors++;
            $display("[TB] FAIL %s: got flags(cnf,code,seq,ydur,pulse)=%b phases_a=%0d phases_b=%0d, expected flags=%b phases_a=%0d phases_b=%0d",
                     name, got, phases_a, phases_b, f, pa, pb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then a complete legal cycle on A followed by B
        addVec(1, 0, G, G, NONE, 0, 0);
        repeat (5) addVec(0, 0, G, R, NONE, 0, 0);
        repeat (3) addVec(0, 0, Y, R, NONE, 0, 0);
        addVec(0, 0, R, R, NONE, 1, 0);
        repeat (5) addVec(0, 0, R, G, NONE, 1, 0);
        repeat (3) addVec(0, 0, R, Y, NONE, 1, 0);
        addVec(0, 0, R, R, NONE, 1, 1);
        // Conflict while A still yellow, then it clears
        addVec(0, 0, G, R, NONE, 1, 1);
        repeat (2) addVec(0, 0, Y, R, NONE, 1, 1);
        addVec(0, 0, Y, G, CNF | PUL, 1, 1);
        addVec(0, 0, R, G, CNF, 2, 1);
        addVec(0, 1, R, G, NONE, 2, 1);
        repeat (2) addVec(0, 0, R, Y, NONE, 2, 1);
        addVec(0, 0, R, R, NONE, 2, 2);
        // Invalid code keeps A in RED; then GREEN->RED is a sequence error
        addVec(0, 0, 3'b110, R, CODE | PUL, 2, 2);
        addVec(0, 0, G, R, CODE, 2, 2);
        addVec(0, 0, R, R, CODE | SEQ | PUL, 2, 2);
        // Short yellow, then over-long yellow
        addVec(0, 1, R, R, NONE, 2, 2);
        addVec(0, 0, G, R, NONE, 2, 2);
        addVec(0, 0, Y, R, NONE, 2, 2);
        addVec(0, 0, R, R, YD | PUL, 3, 2);
        addVec(0, 1, R, R, NONE, 3, 2);
        addVec(0, 0, G, R, NONE, 3, 2);
        repeat (6) addVec(0, 0, Y, R, NONE, 3, 2);
        addVec(0, 0, Y, R, YD | PUL, 3, 2);
        addVec(0, 0, Y, R, YD, 3, 2);
        addVec(0, 0, R, R, YD, 4, 2);
        // clr_err together with a fresh conflict
        addVec(0, 1, G, G, CNF | PUL, 4, 2);
        // Reset mid-yellow
        addVec(1, 0, G, G, NONE, 0, 0);
        addVec(0, 0, G, R, NONE, 0, 0);
        addVec(0, 0, Y, R, NONE, 0, 0);
        addVec(1, 0, Y, R, NONE, 0, 0);
        repeat (2) addVec(0, 0, R, R, NONE, 0, 0);
        // Conflict detected from invalid codes too
        addVec(0, 0, 3'b011, 3'b110, CNF | CODE | PUL, 0, 0);
        addVec(0, 0, R, R, CNF | CODE, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].flags, vecs[i].pa, vecs[i].pb);
        end

        // Phase counter saturation over many legal A cycles
        applyStimulus(1, 0, R, R);
        checkOutput("sat_reset", NONE, 0, 0);
        for (int n = 0; n < 260; n++) begin
            applyStimulus(0, 0, G, R);
            applyStimulus(0, 0, Y, R);
            applyStimulus(0, 0, Y, R);
            applyStimulus(0, 0, R, R);
        end
        checkOutput("phase_sat", NONE, 255, 0);

        // Long green saturates dwell without raising anything
        for (int n = 0; n < 300; n++) applyStimulus(0, 0, G, R);
        checkOutput("long_green", NONE, 255, 0);
        applyStimulus(0, 0, Y, R);
        applyStimulus(0, 0, Y, R);
        applyStimulus(0, 0, R, R);
        checkOutput("after_long_green", NONE, 255, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter YMIN, default 2, minimum legal yellow dwell in clock cycles.
REQ-002 SHALL have parameter YMAX, default 6, maximum legal yellow dwell in clock cycles (YMAX >= YMIN >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports Ra, Ga, Ya  input  1 each  observed lamps, direction A.
REQ-006 SHALL have ports Rb, Gb, Yb  input  1 each  observed lamps, direction B.
REQ-007 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-008 SHALL have ports err_conflict, err_code, err_seq, err_ydur  output  1 each  sticky violation flags.
REQ-009 SHALL have port err_pulse  output  1  one-cycle strobe when any violation is detected in a cycle.
REQ-010 SHALL have ports phases_a, phases_b  output  8 each  completed-phase counts per direction.

Function
REQ-011 SHALL sample all lamp inputs on every rising clk edge; every output is registered and reflects the sample taken at the same edge (one-edge latency).
REQ-012 SHALL decode each direction's {R,G,Y} as RED=100, GREEN=010, YELLOW=001; any other pattern is an invalid code.
REQ-013 SHALL keep per-direction state UNK, GREEN, YELLOW or RED; UNK after reset.
REQ-014 SHALL move from UNK to the decoded state on the first valid code with no sequence check.
REQ-015 SHALL treat GREEN->YELLOW, YELLOW->RED and RED->GREEN as legal; GREEN->RED, YELLOW->GREEN and RED->YELLOW set err_seq, and the state still adopts the new code.
REQ-016 SHALL set err_code on any invalid code in either direction and leave that direction's state and dwell unchanged.
REQ-017 SHALL set err_conflict when, in one sample, both directions have G or Y asserted, regardless of code validity.
REQ-018 SHALL keep an 8-bit per-direction dwell counter: 1 on entry to a state, incremented each sample in the same state, saturating at 255.
REQ-019 SHALL set err_ydur on the sample where YELLOW dwell reaches YMAX+1 (once per yellow interval), or on exit from YELLOW with dwell < YMIN.
REQ-020 SHALL increment phases_x, saturating at 255, on each legal YELLOW->RED transition of direction x whose preceding YELLOW was entered legally from GREEN.
REQ-021 SHALL assert err_pulse for exactly the cycles in which at least one violation of REQ-015..REQ-019 is detected, independent of sticky state.
REQ-022 SHALL hold sticky flags until rst or clr_err; clr_err clears all four; a violation detected in the same cycle as clr_err wins and its flag remains 1.
REQ-023 SHALL evaluate both directions independently each cycle; several flags may set in one cycle.
REQ-024 SHALL not clear phases_a or phases_b on clr_err.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, force both states to UNK, dwell counters and phase counts to 0, and all flags and err_pulse to 0; lamp inputs are ignored that cycle.
REQ-026 SHALL apply reset mid-operation identically, with no violation raised from pre-reset history on the first post-reset sample.

Verification
REQ-027 Legal cycle: A G×5, Y×3, R while B R throughout, then B G×5, Y×3, R -> no flags, err_pulse never 1, phases_a=1, phases_b=1.
REQ-028 Conflict: Ga=1 and Gb=1 for one sample -> err_conflict=1 and err_pulse=1 after that edge; err_pulse 0 next cycle, err_conflict stays 1.
REQ-029 Bad code: {Ra,Ga,Ya}=110 for one sample -> err_code=1, A state unchanged; A GREEN->RED directly -> err_seq=1, phases_a unchanged.
REQ-030 Yellow dwell (YMIN=2, YMAX=6): Y×1 then R -> err_ydur=1 at the R sample; after clr_err, Y held 7 samples -> err_ydur=1 at the 7th Y sample, single err_pulse.
REQ-031 clr_err asserted in the same cycle as a new conflict -> err_conflict remains 1, other flags clear to 0.
REQ-032 Reset mid-yellow: rst during A YELLOW, then A R -> all flags 0, phases_a=0, no err_seq or err_ydur.
